// File: rtl/gen_gr_sb.sv
// General-register file with an integrated RAW scoreboard (busy bit per register).
// Optional write-through forwarding on the read ports when GR_BYPASS_EN is defined.
module gen_gr_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRP  = 2
) (
  input  logic                m_clock,
  input  logic                p_reset,
  input  logic [NRP-1:0]      rs,
  input  logic [NRP*AW-1:0]   rs_n,
  output logic [NRP*XLEN-1:0] s_rd,
  output logic [NRP-1:0]      s_busy,
  input  logic                rsv,
  input  logic [AW-1:0]       rsv_n,
  input  logic                rd,
  input  logic [AW-1:0]       rd_n,
  input  logic [XLEN-1:0]     wd,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] gr_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     pend_q, pend_d;

  // Per-register priority: flush > reserve > writeback; r0 never busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 1; k < NREG; k++) begin
      if (flush)
        busy_d[k] = 1'b0;
      else if (rsv && (rsv_n == AW'(k)))
        busy_d[k] = 1'b1;
      else if (rd && (rd_n == AW'(k)))
        busy_d[k] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pend_d = '0;
    for (int unsigned k = 0; k < NREG; k++)
      pend_d = pend_d + {{AW{1'b0}}, busy_d[k]};
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      for (int unsigned k = 0; k < NREG; k++)
        gr_q[k] <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      if (rd && (rd_n != '0))
        gr_q[rd_n] <= wd;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    s_rd   = '0;
    s_busy = '0;
    for (int unsigned i = 0; i < NRP; i++) begin
      if (p_reset && rs[i] && (rs_n[i*AW +: AW] != '0)) begin
        s_rd[i*XLEN +: XLEN] = gr_q[rs_n[i*AW +: AW]];
        s_busy[i]            = busy_q[rs_n[i*AW +: AW]];
`ifdef GR_BYPASS_EN
        if (rd && (rd_n == rs_n[i*AW +: AW])) begin
          s_rd[i*XLEN +: XLEN] = wd;
          s_busy[i]            = rsv && (rsv_n == rd_n);
        end
`endif
      end
    end
  end

  assign busy_vec = busy_q;
  assign pend_cnt = pend_q;

endmodule
